// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: y[j] = sum_i v[i]*M[i][j] over LANES parallel MACs,
// with optional accumulate-onto-prior-result and ReLU applied at write-back.
module matvec_engine #(
    parameter int  IN_LEN  = 32,
    parameter int  OUT_LEN = 32,
    parameter int  LANES   = 4,
    parameter int  DATA_W  = 16,
    parameter int  FRAC_W  = 8,
    localparam int IW      = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
    localparam int OW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mat_we,
    input  logic [IW-1:0]     mat_row,
    input  logic [OW-1:0]     mat_col,
    input  logic [DATA_W-1:0] mat_data,
    input  logic              vec_we,
    input  logic [IW-1:0]     vec_idx,
    input  logic [DATA_W-1:0] vec_data,
    input  logic              clear,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              ready,
    input  logic [OW-1:0]     res_idx,
    output logic [DATA_W-1:0] res_data
);

    localparam int GROUPS = OUT_LEN / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int ACC_W  = 2 * DATA_W + $clog2(IN_LEN) + 1;
    localparam int SW     = ACC_W + 1;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic signed [DATA_W-1:0]   mat_q [IN_LEN][OUT_LEN];
    logic signed [DATA_W-1:0]   vec_q [IN_LEN];
    logic signed [DATA_W-1:0]   y_q   [OUT_LEN];
    logic signed [ACC_W-1:0]    acc_q [LANES];
    state_t                     state_q;
    logic [GW-1:0]              g_q;
    logic [IW-1:0]              i_q;
    logic [1:0]                 mode_q;
    logic                       busy_q;
    logic                       ready_q;
    logic [DATA_W-1:0]          res_q;

    logic [OW-1:0]              col_s  [LANES];
    logic signed [2*DATA_W-1:0] prod_s [LANES];
    logic signed [DATA_W-1:0]   res_s  [LANES];

    // Shift out the fraction, optionally add the prior result, saturate, then ReLU.
    function automatic logic signed [DATA_W-1:0] lane_result(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] prior,
        input logic [1:0]               md
    );
        logic signed [SW-1:0]     s;
        logic signed [DATA_W-1:0] r;
        s = $signed({acc[ACC_W-1], acc}) >>> FRAC_W;
        if (md[0]) s = s + SW'(prior);
        else       s = s;
        if (s > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
        else                  r = s[DATA_W-1:0];
        if (md[1] && r < 0)   r = '0;
        else                  r = r;
        return r;
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign col_s[l]  = OW'(int'(g_q) * LANES + l);
        assign prod_s[l] = vec_q[i_q] * mat_q[i_q][col_s[l]];
        assign res_s[l]  = lane_result(acc_q[l], y_q[col_s[l]], mode_q);
    end

    // Operand storage: not reset, written only while idle and only for in-range indices.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && mat_we && int'(mat_row) < IN_LEN && int'(mat_col) < OUT_LEN)
            mat_q[mat_row][mat_col] <= mat_data;
        if (state_q == IDLE && vec_we && int'(vec_idx) < IN_LEN)
            vec_q[vec_idx] <= vec_data;
    end

    // Sequencer: one group of LANES outputs per IN_LEN MAC cycles plus one write-back cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            g_q     <= '0;
            i_q     <= '0;
            mode_q  <= 2'b00;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            for (int j = 0; j < OUT_LEN; j++) y_q[j] <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        for (int j = 0; j < OUT_LEN; j++) y_q[j] <= '0;
                    end else if (start) begin
                        mode_q  <= mode;
                        g_q     <= '0;
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MAC;
                        for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
                    end
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + ACC_W'(prod_s[l]);
                    if (int'(i_q) == IN_LEN - 1) begin
                        i_q     <= '0;
                        state_q <= WRITE;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                WRITE: begin
                    for (int l = 0; l < LANES; l++) begin
                        y_q[col_s[l]] <= res_s[l];
                        acc_q[l]      <= '0;
                    end
                    if (int'(g_q) == GROUPS - 1) begin
                        state_q <= DONE;
                    end else begin
                        g_q     <= g_q + 1'b1;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Registered result read port, live in every state.
    always_ff @(posedge clk) begin
        if (rst)                          res_q <= '0;
        else if (int'(res_idx) < OUT_LEN) res_q <= y_q[res_idx];
        else                              res_q <= '0;
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign res_data = res_q;

endmodule
